// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the fetch PC, one-deep imem request port and 1-entry inst buffer.
// Optional FETCH_MISALIGN_TRAP_EN: word-align redirect targets and pulse misalign_o.
module if_fetch_unit #(
  parameter int                   CPU_WIDTH  = 32,
  parameter int                   FLOW_WIDTH = 2,
  parameter logic [CPU_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLOW_WIDTH-1:0] flow_pc_i,
  input  logic                  next_pc_four_i,
  input  logic [CPU_WIDTH-1:0]  next_pc_i,
  output logic                  req_valid_o,
  output logic [CPU_WIDTH-1:0]  req_addr_o,
  input  logic                  req_ready_i,
  input  logic                  rsp_valid_i,
  input  logic [CPU_WIDTH-1:0]  rsp_data_i,
  output logic                  inst_valid_o,
  output logic [CPU_WIDTH-1:0]  inst_o,
  output logic [CPU_WIDTH-1:0]  inst_pc_o,
  output logic                  fetch_pc_hold_o
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                  misalign_o
`endif
);

  // flow_pc_i: 0 work, 1 stop, 2 refresh; 3 behaves like stop
  localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = FLOW_WIDTH'(0);
  localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = FLOW_WIDTH'(2);
  localparam logic [CPU_WIDTH-1:0]  NOP          = CPU_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_e;

  state_e               state_q, state_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic [CPU_WIDTH-1:0] inst_q, inst_d;
  logic [CPU_WIDTH-1:0] ipc_q, ipc_d;
  logic                 full_q, full_d;

  logic                 work;
  logic                 redirect;
  logic                 refresh;
  logic                 flush;
  logic                 consume;
  logic                 accept;
  logic                 capture;
  logic [CPU_WIDTH-1:0] target;

  assign work     = flow_pc_i == FLOW_WORK;
  assign redirect = work & ~next_pc_four_i;
  assign refresh  = flow_pc_i == FLOW_REFRESH;
  assign flush    = redirect | refresh;
  assign consume  = work & full_q;

  // never prefetch past the single buffered word
  assign req_valid_o = (state_q == S_REQ) & ~full_q & ~rst;
  assign req_addr_o  = pc_q;
  assign accept      = req_valid_o & req_ready_i;
  assign capture     = (state_q == S_WAIT) & rsp_valid_i & ~flush;

  assign inst_valid_o    = full_q;
  assign inst_o          = inst_q;
  assign inst_pc_o       = ipc_q;
  assign fetch_pc_hold_o = ~full_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q;

  assign target     = {next_pc_i[CPU_WIDTH-1:2], 2'b00};
  assign misalign_o = mis_q;

  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= redirect & (|next_pc_i[1:0]);
  end
`else
  assign target = next_pc_i;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    full_d  = full_q;

    unique case (state_q)
      S_REQ:  if (accept) state_d = flush ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (rsp_valid_i) state_d = S_REQ;
        else if (flush)  state_d = S_DROP;
      end
      S_DROP: if (rsp_valid_i) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    if (flush | consume) full_d = 1'b0;
    if (capture) begin
      full_d = 1'b1;
      inst_d = rsp_data_i;
      ipc_d  = pc_q;
    end

    if (redirect)     pc_d = target;
    else if (consume) pc_d = ipc_q + CPU_WIDTH'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= NOP;
      ipc_q   <= RESET_PC;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      full_q  <= full_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random flow/memory traffic
// compared every cycle against a transaction-level fetch model.
module tb_if_fetch_unit;

  localparam logic [1:0] WORK = 2'd0;
  localparam logic [1:0] STOP = 2'd1;
  localparam logic [1:0] REFR = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  flow_pc_i = STOP;
  logic        next_pc_four_i = 1'b1;
  logic [31:0] next_pc_i = '0;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i = 1'b0;
  logic        rsp_valid_i = 1'b0;
  logic [31:0] rsp_data_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        fetch_pc_hold_o;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .flow_pc_i      (flow_pc_i),
    .next_pc_four_i (next_pc_four_i),
    .next_pc_i      (next_pc_i),
    .req_valid_o    (req_valid_o),
    .req_addr_o     (req_addr_o),
    .req_ready_i    (req_ready_i),
    .rsp_valid_i    (rsp_valid_i),
    .rsp_data_i     (rsp_data_i),
    .inst_valid_o   (inst_valid_o),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o),
    .fetch_pc_hold_o(fetch_pc_hold_o)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_o     (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: fetch pc, buffered word, one outstanding fetch (live or stale)
  bit          m_full  = 0;
  logic [31:0] m_bpc   = '0;
  logic [31:0] m_pc    = '0;
  bit          m_out   = 0;
  bit          m_stale = 0;
  logic [31:0] m_req   = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  bit          m_mis   = 0;
`endif

  // memory: one request in flight, variable latency
  bit          mem_busy = 0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;
  int          lat_lo   = 1;
  int          lat_hi   = 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit rv;
    rv = !rst && !m_out && !m_full;
    chk("req_valid", 32'(req_valid_o), 32'(rv));
    if (rv) chk("req_addr", req_addr_o, m_pc);
    chk("inst_valid", 32'(inst_valid_o), 32'(m_full));
    chk("hold", 32'(fetch_pc_hold_o), 32'(!m_full));
    if (m_full) begin
      chk("inst_pc", inst_pc_o, m_bpc);
      chk("inst", inst_o, memf(m_bpc));
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign", 32'(misalign_o), 32'(m_mis));
`endif
  endtask

  task automatic step(input logic [1:0] fl, input bit four,
                      input logic [31:0] npc, input bit rdy, input bit r);
    bit rsp, acc_m, redir, flush, cons, new_full;
    logic [31:0] tgt;
    @(negedge clk);
    compare();
    rsp = 0;
    if (mem_busy) begin
      mem_wait--;
      if (mem_wait == 0) rsp = 1;
    end
    rst            = r;
    flow_pc_i      = fl;
    next_pc_four_i = four;
    next_pc_i      = npc;
    req_ready_i    = rdy;
    rsp_valid_i    = rsp;
    rsp_data_i     = rsp ? memf(mem_addr) : $urandom;
    #1;
    if (rsp) mem_busy = 0;
    if (req_valid_o && rdy) begin
      mem_busy = 1;
      mem_wait = $urandom_range(lat_hi, lat_lo);
      mem_addr = req_addr_o;
    end
    if (r) begin
      m_full = 0; m_pc = '0; m_out = 0; m_stale = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_mis = 0;
`endif
    end else begin
      acc_m = !m_out && !m_full && rdy;
      redir = (fl == WORK) && !four;
      flush = redir || (fl == REFR);
      cons  = m_full && (fl == WORK);
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt   = {npc[31:2], 2'b00};
      m_mis = redir && (npc[1:0] != 2'b00);
`else
      tgt   = npc;
`endif
      if (redir)     m_pc = tgt;
      else if (cons) m_pc = m_bpc + 32'd4;
      new_full = m_full && !(flush || cons);
      if (rsp && m_out && !m_stale && !flush) begin
        new_full = 1;
        m_bpc    = m_req;
      end
      m_full = new_full;
      if (rsp)                m_out = 0;
      else if (m_out && flush) m_stale = 1;
      if (acc_m) begin
        m_out   = 1;
        m_stale = flush;
        m_req   = m_pc;
      end
    end
  endtask

  task automatic wait_valid(input string name);
    int i = 0;
    do begin
      step(STOP, 1, '0, 1, 0);
      i++;
    end while (!inst_valid_o && i < 30);
    chk(name, 32'(inst_valid_o), 32'd1);
  endtask

  initial begin
    int first;
    logic [31:0] pcs[$];
    logic [31:0] s_inst, s_pc;
    int n;

    // reset state
    step(STOP, 1, '0, 1, 1);
    step(STOP, 1, '0, 1, 1);
    chk("rst_inst", inst_o, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc_o, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_hold", 32'(fetch_pc_hold_o), 32'd1);
    chk("rst_req_valid", 32'(req_valid_o), 32'd0);

    // sequential fetch, 1-cycle memory: accept c0, rsp c1, visible c2
    first = -1;
    for (int c = 0; c < 10; c++) begin
      step(WORK, 1, '0, 1, 0);
      if (inst_valid_o) begin
        if (first < 0) first = c;
        pcs.push_back(inst_pc_o);
      end
    end
    chk("first_valid_cycle", 32'(first), 32'd2);
    chk("seq_count", 32'(pcs.size()), 32'd3);
    if (pcs.size() == 3) begin
      chk("seq_pc0", pcs[0], 32'h0);
      chk("seq_pc1", pcs[1], 32'h4);
      chk("seq_pc2", pcs[2], 32'h8);
    end

    // stop with buffer full
    wait_valid("stop_wait");
    s_inst = inst_o;
    s_pc   = inst_pc_o;
    for (int i = 0; i < 5; i++) begin
      step(STOP, 1, '0, 1, 0);
      chk("stop_inst", inst_o, s_inst);
      chk("stop_pc", inst_pc_o, s_pc);
      chk("stop_req_valid", 32'(req_valid_o), 32'd0);
      chk("stop_hold", 32'(fetch_pc_hold_o), 32'd0);
    end

    // redirect while waiting on fetch of 0x8
    lat_lo = 2; lat_hi = 2;
    step(STOP, 1, '0, 1, 1);
    step(STOP, 1, '0, 1, 1);
    n = 0;
    do begin
      step(WORK, 1, '0, 1, 0);
      n++;
    end while (!(req_valid_o && req_addr_o == 32'h8) && n < 30);
    chk("reach_req8", req_addr_o, 32'h8);
    step(WORK, 0, 32'h100, 1, 0);
    chk("redir_in_wait_req", 32'(req_valid_o), 32'd0);
    wait_valid("redir_wait");
    chk("redir_pc", inst_pc_o, 32'h100);
    chk("redir_inst", inst_o, memf(32'h100));

    // memory not ready for 4 cycles
    step(WORK, 1, '0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(WORK, 1, '0, 0, 0);
      chk("stall_req_valid", 32'(req_valid_o), 32'd1);
      chk("stall_addr", req_addr_o, 32'h104);
      chk("stall_hold", 32'(fetch_pc_hold_o), 32'd1);
    end

    // pc wrap at top of address space
    wait_valid("wrap_pre");
    step(WORK, 0, 32'hFFFF_FFFC, 1, 0);
    wait_valid("wrap_wait");
    chk("wrap_pc", inst_pc_o, 32'hFFFF_FFFC);
    step(WORK, 1, '0, 1, 0);
    step(STOP, 1, '0, 1, 0);
    chk("wrap_req_valid", 32'(req_valid_o), 32'd1);
    chk("wrap_addr", req_addr_o, 32'h0);

    // unaligned redirect target
    wait_valid("mis_pre");
    step(WORK, 0, 32'h102, 1, 0);
    step(STOP, 1, '0, 1, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_addr", req_addr_o, 32'h100);
    chk("mis_pulse", 32'(misalign_o), 32'd1);
    step(STOP, 1, '0, 1, 0);
    chk("mis_clear", 32'(misalign_o), 32'd0);
`else
    chk("unaligned_addr", req_addr_o, 32'h102);
`endif

    // random traffic
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      int f;
      logic [1:0] fl;
      f  = $urandom_range(99);
      fl = (f < 60) ? WORK : (f < 88) ? STOP : REFR;
      if ($urandom_range(299) == 0) begin
        repeat (4) step(STOP, 1, '0, 1, 1);
      end else begin
        step(fl, $urandom_range(99) < 80, $urandom,
             $urandom_range(99) < 70, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
